// File: rtl/yarp_data_mem_resp_if.sv
// ----------------------------------------------------------------------------
// yarp_data_mem_resp_if : core <-> data memory request/response bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface yarp_data_mem_resp_if;
   logic        req_i;
   logic [31:0] addr_i;
   logic [1:0]  byte_en_i;
   logic        wr_i;
   logic [31:0] wr_data_i;
   logic [31:0] rd_data_o;
   logic        ready_o;
   logic        err_o;

   modport master (
      output req_i, addr_i, byte_en_i, wr_i, wr_data_i,
      input  rd_data_o, ready_o, err_o
   );

   modport slave (
      input  req_i, addr_i, byte_en_i, wr_i, wr_data_i,
      output rd_data_o, ready_o, err_o
   );
endinterface

`default_nettype wire

// File: rtl/yarp_data_mem_resp.sv
// ----------------------------------------------------------------------------
// yarp_data_mem_resp : wait-stated byte/half/word data memory, one access at a time
// Optional error checking with macro YARP_DMEM_ERR_EN.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module yarp_data_mem_resp #(
   parameter int unsigned MEM_DEPTH   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  wire logic           clk,
   input  wire logic           reset,
   yarp_data_mem_resp_if.slave bus
);
   localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  be_q, be_d;
   logic        wr_q, wr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;

   logic [31:0]      w_offset;
   logic [31:0]      w_word_full;
   logic [31:0]      w_word;
   logic [IDX_W-1:0] w_idx;
   logic             w_err;
   logic             w_is_byte;
   logic             w_is_half;
   logic             w_mem_we;
   logic [3:0]       w_lane_we;
   logic [31:0]      w_wdata_rep;
   logic [31:0]      w_rd_word;
   logic [31:0]      w_rd_sel;
   logic             w_unused;

   assign w_offset    = addr_q - BASE_ADDR;
   assign w_word_full = {2'b00, w_offset[31:2]};
   assign w_is_byte   = (be_q == 2'b00);
   assign w_is_half   = (be_q == 2'b01);

`ifdef YARP_DMEM_ERR_EN
   assign w_err  = (be_q == 2'b10)
                || (w_is_half && addr_q[0])
                || ((be_q == 2'b11) && (addr_q[1:0] != 2'b00))
                || (addr_q < BASE_ADDR)
                || (w_word_full >= MEM_DEPTH);
   assign w_word = w_word_full;
`else
   // Without checking, misaligned offsets are dropped by the lane logic and the index wraps
   assign w_err  = 1'b0;
   assign w_word = w_word_full % MEM_DEPTH;
`endif

   assign w_idx    = w_word[IDX_W-1:0];
   assign w_unused = ^{w_word, w_offset[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= 32'd0;
         be_q      <= 2'b00;
         wr_q      <= 1'b0;
         wdata_q   <= 32'd0;
         rd_data_q <= 32'd0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      w_mem_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_i) begin
               addr_d  = bus.addr_i;
               be_d    = bus.byte_en_i;
               wr_d    = bus.wr_i;
               wdata_d = bus.wr_data_i;
               cnt_d   = WAIT_LOAD;
               state_d = (WAIT_LOAD != 4'd0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            // Outputs register here so ready_o lands WAIT_STATES+1 cycles after accept
            ready_d   = 1'b1;
            err_d     = w_err;
            rd_data_d = (wr_q || w_err) ? 32'd0 : w_rd_sel;
            w_mem_we  = wr_q && !w_err;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      w_lane_we = 4'b0000;
      if (w_mem_we) begin
         if (w_is_byte) begin
            w_lane_we[addr_q[1:0]] = 1'b1;
         end else if (w_is_half) begin
            w_lane_we = addr_q[1] ? 4'b1100 : 4'b0011;
         end else begin
            w_lane_we = 4'b1111;
         end
      end
   end

   assign w_wdata_rep = w_is_byte ? {4{wdata_q[7:0]}}
                      : w_is_half ? {2{wdata_q[15:0]}}
                      : wdata_q;

   // One byte-wide array per lane keeps each storage element single-driven
   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] mem_q [MEM_DEPTH];

      always_ff @(posedge clk) begin
         if (w_lane_we[l]) begin
            mem_q[w_idx] <= w_wdata_rep[8*l +: 8];
         end
      end

      assign w_rd_word[8*l +: 8] = mem_q[w_idx];
   end

   always_comb begin
      w_rd_sel = w_rd_word;
      if (w_is_byte) begin
         unique case (addr_q[1:0])
            2'd0:    w_rd_sel = {24'd0, w_rd_word[7:0]};
            2'd1:    w_rd_sel = {24'd0, w_rd_word[15:8]};
            2'd2:    w_rd_sel = {24'd0, w_rd_word[23:16]};
            default: w_rd_sel = {24'd0, w_rd_word[31:24]};
         endcase
      end else if (w_is_half) begin
         w_rd_sel = addr_q[1] ? {16'd0, w_rd_word[31:16]} : {16'd0, w_rd_word[15:0]};
      end
   end

   assign bus.rd_data_o = rd_data_q;
   assign bus.ready_o   = ready_q;
   assign bus.err_o     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_yarp_data_mem_resp.sv
// ----------------------------------------------------------------------------
// tb_yarp_data_mem_resp : scoreboard bench over three wait-state configurations
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_yarp_data_mem_resp;
   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int          DEPTH = 1024;

   typedef struct {
      logic [31:0] rd;
      logic        er;
      int          lat;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        req  [3];
   logic [31:0] addr [3];
   logic [1:0]  be   [3];
   logic        wr   [3];
   logic [31:0] wd   [3];
   logic [2:0]  rdy;
   logic [2:0]  erv;
   logic [31:0] rdd  [3];

   logic [7:0]  mb [3][4096];
   exp_t        exp_q [$];
   int          n_tests;
   int          n_fail;

   function automatic int ws(input int k);
      return (k == 0) ? 1 : (k == 1) ? 0 : 3;
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_dut
      yarp_data_mem_resp_if bus ();
      assign bus.req_i     = req[k];
      assign bus.addr_i    = addr[k];
      assign bus.byte_en_i = be[k];
      assign bus.wr_i      = wr[k];
      assign bus.wr_data_i = wd[k];
      assign rdy[k]        = bus.ready_o;
      assign erv[k]        = bus.err_o;
      assign rdd[k]        = bus.rd_data_o;

      yarp_data_mem_resp #(
         .MEM_DEPTH  (DEPTH),
         .BASE_ADDR  (BASE),
         .WAIT_STATES(ws(k))
      ) dut (
         .clk  (clk),
         .reset(reset),
         .bus  (bus)
      );
   end

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Byte-addressed reference memory; returns what a read should show and whether it errors
   function automatic void model(input int k, input logic w, input logic [1:0] b,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rd, output logic er);
      logic [31:0] off;
      logic [11:0] bi;
      int          n;
      off = a - BASE;
      n   = (b == 2'b00) ? 1 : (b == 2'b01) ? 2 : 4;
      rd  = 32'd0;
      er  = 1'b0;
`ifdef YARP_DMEM_ERR_EN
      if (b == 2'b10) er = 1'b1;
      if ((n == 2) && a[0]) er = 1'b1;
      if ((n == 4) && (a[1:0] != 2'b00)) er = 1'b1;
      if ((a < BASE) || (off >= 32'(4 * DEPTH))) er = 1'b1;
`else
      off = (off & ~(32'(n) - 32'd1)) % 32'(4 * DEPTH);
`endif
      if (!er) begin
         for (int i = 0; i < n; i++) begin
            bi = 12'(off + 32'(i));
            if (w) mb[k][bi] = d[8*i +: 8];
            else   rd[8*i +: 8] = mb[k][bi];
         end
      end
   endfunction

   task automatic txn(input int k, input logic w, input logic [1:0] b,
                      input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   cyc;
      model(k, w, b, a, d, e.rd, e.er);
      e.lat = ws(k) + 1;
      exp_q.push_back(e);
      req[k]  = 1'b1;
      wr[k]   = w;
      be[k]   = b;
      addr[k] = a;
      wd[k]   = d;
      cyc     = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!rdy[k] && (cyc < 40));
      req[k] = 1'b0;
      e = exp_q.pop_front();
      chk("ready", 32'(rdy[k]), 32'd1);
      chk("latency", 32'(cyc - 1), 32'(e.lat));
      chk("rd_data", rdd[k], e.rd);
      chk("err", 32'(erv[k]), 32'(e.er));
      @(posedge clk); #1;
      chk("pulse", 32'(rdy[k]), 32'd0);
   endtask

   initial begin
      exp_t e;
      logic seen;
      n_tests = 0;
      n_fail  = 0;
      clk     = 1'b0;
      reset   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req[k] = 1'b0; addr[k] = 32'd0; be[k] = 2'b00; wr[k] = 1'b0; wd[k] = 32'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", 32'(rdy[k]), 32'd0);
         chk("rst_err", 32'(erv[k]), 32'd0);
         chk("rst_rd", rdd[k], 32'd0);
      end
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // Basic word/byte/half traffic, WAIT_STATES=1
      txn(0, 1'b1, 2'b11, 32'h2000, 32'hDEAD_BEEF);
      txn(0, 1'b0, 2'b11, 32'h2000, 32'h0);
      chk("beef", rdd[0], 32'hDEAD_BEEF);
      repeat (3) @(posedge clk);
      #1;
      chk("hold", rdd[0], 32'hDEAD_BEEF);
      txn(0, 1'b1, 2'b00, 32'h2002, 32'h0000_0055);
      txn(0, 1'b0, 2'b11, 32'h2000, 32'h0);
      chk("de55beef", rdd[0], 32'hDE55_BEEF);
      txn(0, 1'b0, 2'b01, 32'h2002, 32'h0);
      chk("de55", rdd[0], 32'h0000_DE55);
      for (int i = 0; i < 4; i++) txn(0, 1'b0, 2'b00, BASE + 32'(i), 32'h0);
      txn(0, 1'b0, 2'b01, 32'h2000, 32'h0);
      txn(0, 1'b1, 2'b11, 32'h2004, 32'h1122_3344);
      txn(0, 1'b1, 2'b01, 32'h2006, 32'h1234_ABCD);
      txn(0, 1'b0, 2'b11, 32'h2004, 32'h0);
      txn(0, 1'b1, 2'b00, 32'h2005, 32'hFFFF_FF99);
      txn(0, 1'b0, 2'b11, 32'h2004, 32'h0);

      // Misaligned, reserved and out-of-window accesses; outcome depends on the build
      txn(0, 1'b1, 2'b11, 32'h2001, 32'hCAFE_F00D);
      txn(0, 1'b0, 2'b11, 32'h2000, 32'h0);
      txn(0, 1'b0, 2'b11, 32'h2003, 32'h0);
      txn(0, 1'b0, 2'b10, 32'h2000, 32'h0);
      txn(0, 1'b0, 2'b01, 32'h2001, 32'h0);
      txn(0, 1'b0, 2'b11, 32'h3000, 32'h0);
      txn(0, 1'b1, 2'b11, 32'h2FFC, 32'h0BAD_F00D);
      txn(0, 1'b1, 2'b00, 32'h1FFC, 32'h0000_0077);
      txn(0, 1'b0, 2'b11, 32'h2FFC, 32'h0);
      txn(0, 1'b1, 2'b11, 32'h3004, 32'h5A5A_5A5A);
      txn(0, 1'b0, 2'b11, 32'h2004, 32'h0);

      // Back-to-back requests with req_i held high, WAIT_STATES=0
      txn(1, 1'b1, 2'b11, 32'h2010, 32'hA5A5_0001);
      txn(1, 1'b1, 2'b11, 32'h2014, 32'h5A5A_0002);
      model(1, 1'b0, 2'b11, 32'h2010, 32'h0, e.rd, e.er);
      e.lat = 1;
      exp_q.push_back(e);
      model(1, 1'b0, 2'b11, 32'h2014, 32'h0, e.rd, e.er);
      exp_q.push_back(e);
      req[1] = 1'b1; wr[1] = 1'b0; be[1] = 2'b11; addr[1] = 32'h2010;
      @(posedge clk); #1;
      chk("b2b_c0", 32'(rdy[1]), 32'd0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("b2b_c1", 32'(rdy[1]), 32'd1);
      chk("b2b_rd1", rdd[1], e.rd);
      addr[1] = 32'h2014;
      @(posedge clk); #1;
      chk("b2b_c2", 32'(rdy[1]), 32'd0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("b2b_c3", 32'(rdy[1]), 32'd1);
      chk("b2b_rd2", rdd[1], e.rd);
      req[1] = 1'b0;
      @(posedge clk); #1;
      chk("b2b_c4", 32'(rdy[1]), 32'd0);

      // Longer wait, then reset during the wait of a write, WAIT_STATES=3
      txn(2, 1'b1, 2'b11, 32'h2020, 32'h1111_2222);
      txn(2, 1'b0, 2'b11, 32'h2020, 32'h0);
      txn(2, 1'b0, 2'b01, 32'h2022, 32'h0);
      req[2] = 1'b1; wr[2] = 1'b1; be[2] = 2'b11; addr[2] = 32'h2020; wd[2] = 32'h9999_9999;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req[2] = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("abort_rd", rdd[2], 32'd0);
      chk("abort_rdy", 32'(rdy[2]), 32'd0);
      chk("abort_err", 32'(erv[2]), 32'd0);
      @(negedge clk) reset = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         seen = seen | rdy[2];
      end
      chk("abort_no_ready", 32'(seen), 32'd0);
      txn(2, 1'b0, 2'b11, 32'h2020, 32'h0);
      chk("abort_old", rdd[2], 32'h1111_2222);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/yarp_data_mem_resp.md
YARP_DATA_MEM_RESP -- requirements
Module: yarp_data_mem_resp

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024: number of 32-bit words in the array.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_2000: byte address of word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 1: cycles inserted between accept and response; legal range 0..15.
REQ-004 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_i, input, 1: request from core; held high until ready_o.
REQ-007 SHALL have port addr_i, input, 32: byte address.
REQ-008 SHALL have port byte_en_i, input, 2: access size; 2'b00 byte, 2'b01 half, 2'b11 word, 2'b10 reserved.
REQ-009 SHALL have port wr_i, input, 1: 1 write, 0 read.
REQ-010 SHALL have port wr_data_i, input, 32: write data, right-justified.
REQ-011 SHALL have port rd_data_o, output, 32: read data, right-justified, upper bits zero.
REQ-012 SHALL have port ready_o, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port err_o, output, 1: error flag, valid only when ready_o=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 In IDLE with req_i=1, SHALL latch addr_i, byte_en_i, wr_i and wr_data_i, and load the wait counter with WAIT_STATES.
REQ-016 On accept, SHALL go to WAIT if WAIT_STATES>0, else go directly to RESP.
REQ-017 In WAIT, SHALL decrement the counter each cycle and go to RESP on the cycle the counter reads 1.
REQ-018 Latency from the accept edge to ready_o high SHALL equal WAIT_STATES+1 cycles.
REQ-019 In RESP, SHALL assert ready_o for exactly one cycle, perform the latched access, and return to IDLE.
REQ-020 Inputs SHALL be ignored outside IDLE; a req_i still high after ready_o is a new request, accepted the cycle after RESP.
REQ-021 Word index SHALL equal (addr - BASE_ADDR)>>2; lane SHALL equal addr[1:0].
REQ-022 Byte write SHALL update only lane addr[1:0] with wr_data_i[7:0].
REQ-023 Half write SHALL update lanes {addr[1],0} and {addr[1],1} with wr_data_i[15:0].
REQ-024 Word write SHALL update all four lanes.
REQ-025 Reads SHALL return the selected byte, half or word right-justified and zero-extended in rd_data_o, registered and valid with ready_o; the core performs sign extension.
REQ-026 Writes SHALL drive rd_data_o to 0.
REQ-027 rd_data_o SHALL hold its value until the next RESP.
REQ-028 A write followed by a read of the same address SHALL return the written data; there are no hazards because accesses are serialized.
REQ-029 An error response SHALL leave the array unmodified and drive rd_data_o to 0.

Reset
REQ-030 When reset is asserted, SHALL immediately force the FSM to IDLE, the counter to 0, and ready_o, err_o and rd_data_o to 0.
REQ-031 Reset asserted mid-transaction SHALL abort it, with no write performed and no ready_o.
REQ-032 Array contents SHALL NOT be reset.

Configuration
REQ-033 Macro YARP_DMEM_ERR_EN, when defined: err_o=1 with ready_o for byte_en 2'b10, for half accesses with addr[0]=1, for word accesses with addr[1:0]!=0, and for addresses outside BASE_ADDR..BASE_ADDR+4*MEM_DEPTH-1.
REQ-034 Macro YARP_DMEM_ERR_EN, when undefined: err_o SHALL be tied to 0.
REQ-035 Macro YARP_DMEM_ERR_EN, when undefined: half accesses SHALL ignore addr[0] and word accesses SHALL ignore addr[1:0].
REQ-036 Macro YARP_DMEM_ERR_EN, when undefined: byte_en 2'b10 SHALL be treated as word.
REQ-037 Macro YARP_DMEM_ERR_EN, when undefined: the word index SHALL wrap modulo MEM_DEPTH.

Verification
REQ-038 Word write 32'hDEAD_BEEF to 32'h2000, then word read of 32'h2000 -> rd_data_o=32'hDEAD_BEEF; ready_o 2 cycles after each accept (WAIT_STATES=1).
REQ-039 After REQ-038, byte write 32'h0000_0055 to 32'h2002, then word read of 32'h2000 -> 32'hDE55_BEEF; half read of 32'h2002 -> 32'h0000_DE55.
REQ-040 WAIT_STATES=0 and req_i held high for two back-to-back reads -> ready_o high on cycles 1 and 3 after the first accept, low on cycle 2.
REQ-041 With YARP_DMEM_ERR_EN defined: word write to 32'h2001 -> err_o=1 with ready_o and array unchanged; access to 32'h3000 (MEM_DEPTH=1024) -> err_o=1.
REQ-042 Without YARP_DMEM_ERR_EN: word read of 32'h2003 -> same data as 32'h2000; err_o=0.
REQ-043 Reset asserted during WAIT of a write -> ready_o stays 0; a subsequent read shows the old data.
